// File: rtl/tick_pkg.sv
// Shared timing constants for the microwave timer path.
package tick_pkg;
  localparam int unsigned CLK_HZ       = 50_000_000;
  localparam int unsigned TICK_1HZ_DIV = CLK_HZ;
  localparam int unsigned TICK_2HZ_DIV = CLK_HZ / 2;
  localparam int unsigned SEC_PER_MIN  = 60;
endpackage

// File: rtl/mod_counter.sv
// Modulo counter with synchronous clear; wrap_o flags the enabled terminal-count edge.
module mod_counter #(
  parameter int unsigned    W       = 8,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W:0]   modulus_i,
  output logic [W-1:0] count_o,
  output logic         wrap_o
);
  logic [W-1:0] count_q, count_d;
  logic         last;

  // modulus is one bit wider so a modulus of exactly 2**W stays representable
  assign last    = ({1'b0, count_q} == (modulus_i - (W+1)'(1)));
  assign wrap_o  = en_i & last;
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = last ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= RST_VAL;
    else         count_q <= count_d;
  end
endmodule

// File: rtl/tick_generator.sv
// Clock-enable generator: periodic tick, square wave, slow tick and a
// runtime divisor that only takes effect at a period boundary or restart.
module tick_generator
  import tick_pkg::*;
#(
  parameter int unsigned CNT_W   = 26,
  parameter int unsigned DIVISOR = TICK_1HZ_DIV,
  parameter int unsigned SLOW_N  = SEC_PER_MIN,
  parameter int unsigned SLOW_W  = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             restart,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_value,
  output logic             tick,
  output logic             square,
  output logic             tick_slow,
  output logic             div_err,
  output logic [CNT_W-1:0] cur_div
);
  if (DIVISOR < 2 || longint'(DIVISOR) >= (longint'(1) << CNT_W) ||
      SLOW_N < 1 || longint'(SLOW_N) > (longint'(1) << SLOW_W)) begin : g_param_check
    $error("tick_generator: illegal DIVISOR/CNT_W/SLOW_N/SLOW_W combination");
  end

  localparam logic [SLOW_W:0] SLOW_MOD = (SLOW_W+1)'(SLOW_N);

  logic [CNT_W-1:0]  cnt, next_cnt, new_div;
  logic [SLOW_W-1:0] slow_cnt;
  logic              per_wrap, slow_wrap, tc, load_ok, has_new, apply;
  logic              unused_slow;

  logic [CNT_W-1:0]  cur_div_q, cur_div_d, pend_val_q, pend_val_d;
  logic              pend_q, pend_d;
  logic              tick_q, tick_d, square_q, square_d;
  logic              tick_slow_q, tick_slow_d, div_err_q, div_err_d;

  mod_counter #(.W(CNT_W)) u_period (
    .clk_i     (clock),
    .rst_ni    (reset_n),
    .en_i      (enable),
    .clr_i     (restart),
    .modulus_i ({1'b0, cur_div_q}),
    .count_o   (cnt),
    .wrap_o    (per_wrap)
  );

  mod_counter #(.W(SLOW_W)) u_slow (
    .clk_i     (clock),
    .rst_ni    (reset_n),
    .en_i      (tc),
    .clr_i     (restart),
    .modulus_i (SLOW_MOD),
    .count_o   (slow_cnt),
    .wrap_o    (slow_wrap)
  );

  assign unused_slow = ^slow_cnt;

  always_comb begin
    tc        = per_wrap & ~restart;
    apply     = restart | tc;
    load_ok   = div_load && (div_value >= CNT_W'(2));
    div_err_d = div_load && (div_value <  CNT_W'(2));
    // a load arriving on the applying edge itself wins over the stored one
    has_new   = load_ok | pend_q;
    new_div   = load_ok ? div_value : pend_val_q;

    cur_div_d  = cur_div_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    if (apply && has_new) begin
      cur_div_d = new_div;
      pend_d    = 1'b0;
    end else if (load_ok) begin
      pend_d     = 1'b1;
      pend_val_d = div_value;
    end

    next_cnt    = per_wrap ? '0 : cnt + CNT_W'(1);
    tick_d      = tc;
    tick_slow_d = slow_wrap;
    square_d    = square_q;
    if (restart)     square_d = 1'b0;
    else if (enable) square_d = (next_cnt >= (cur_div_q >> 1));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur_div_q   <= CNT_W'(DIVISOR);
      pend_val_q  <= '0;
      pend_q      <= 1'b0;
      tick_q      <= 1'b0;
      square_q    <= 1'b0;
      tick_slow_q <= 1'b0;
      div_err_q   <= 1'b0;
    end else begin
      cur_div_q   <= cur_div_d;
      pend_val_q  <= pend_val_d;
      pend_q      <= pend_d;
      tick_q      <= tick_d;
      square_q    <= square_d;
      tick_slow_q <= tick_slow_d;
      div_err_q   <= div_err_d;
    end
  end

  assign tick      = tick_q;
  assign square    = square_q;
  assign tick_slow = tick_slow_q;
  assign div_err   = div_err_q;
  assign cur_div   = cur_div_q;
endmodule
